irq_latch_arbiter: RTL and testbench
====================================

// Module: irq_latch_arbiter
// PURPOSE
//  Upstream stage of the priority interrupt decoder. It synchronises N asynchronous
//  interrupt sources and turns each rising edge into a sticky pending bit. It
//  arbitrates the unmasked pending bits with fixed priority, highest index wins
//  (the 3'b1?? > 3'b?1? > 3'b??1 ordering). It then runs a req/ack/eoi handshake
//  with the CPU side, one interrupt in service at a time.
// PARAMETERS
//  N_SRC        3   number of interrupt sources (2..8)
//  SYNC_STAGES  2   synchroniser flops per source (>=2)
//  ID_W         $clog2(N_SRC)  width of irq_id (localparam, derived)
// PORTS
//  clk          in   1       single system clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  irq_src      in   N_SRC   raw asynchronous interrupt lines, rising-edge active
//  irq_mask     in   N_SRC   1 = source masked; it still latches but never requests
//  irq_ack      in   1       CPU accepts the current request (sampled in REQ only)
//  irq_eoi      in   1       CPU end-of-interrupt (sampled in SERVICE only)
//  irq_req      out  1       registered request to the CPU
//  irq_id       out  ID_W    index of the requested/in-service source, registered
//  irq_pending  out  N_SRC   registered sticky pending vector (this is the irq[] vector)
//  irq_busy     out  1       1 while state is SERVICE
// BEHAVIOUR
//  Reset: all sync flops, edge-history flops, irq_pending, irq_req, irq_id and
//   irq_busy go to 0. State goes to IDLE. Reset mid-handshake abandons it; no ack
//   or eoi is remembered.
//  Edge detect: edge[i] = s_last[i] & ~s_prev[i], where s_last is the last sync stage.
//   A level held high produces exactly one edge.
//  Pending: pend_next = (pend & ~clr) | edge. Set wins over clear on the same bit in
//   the same cycle, so no edge is lost.
//  Arbitration (comb): cand = pending & ~irq_mask. win = highest set index of cand.
//   any = |cand.
//  FSM states (enum): IDLE, REQ, SERVICE.
//   IDLE:    if any, load irq_id<=win, set irq_req<=1, go to REQ. Otherwise stay.
//   REQ:     irq_id frozen. If irq_ack: clear pending[irq_id], irq_req<=0,
//            irq_busy<=1, go to SERVICE. A higher-priority arrival in REQ does not
//            preempt. If the current bit becomes masked while in REQ and no ack
//            arrives: irq_req<=0, go to IDLE next cycle.
//   SERVICE: irq_id held. New edges keep latching. On irq_eoi: irq_busy<=0, go to IDLE.
//  ack outside REQ and eoi outside SERVICE are ignored. ack and eoi in the same
//   cycle in REQ: the ack is taken, the eoi is ignored.
//  Latency: from the clk edge that first samples irq_src high, irq_req rises after
//   SYNC_STAGES+2 further edges (4 with the default). Back-to-back: IDLE to REQ takes
//   1 cycle after eoi.
//  A re-triggered edge on an in-service source sets its pending bit again and is
//   served after eoi.
// STRUCTURE
//  Package irq_pkg holds: typedef enum logic[1:0] {IDLE,REQ,SERVICE} irq_state_t,
//   and the default constants N_SRC_DEF=3 and SYNC_STAGES_DEF=2.
//  Sub-module sync_edge_detect (#SYNC_STAGES, 1-bit): synchroniser plus rising-edge
//   pulse, instantiated N_SRC times via generate for.
//  Top level holds: pending register, comb priority pick (priority-style loop),
//   and the FSM as always_ff + always_comb.
// TESTING
//  1 Single edge: irq_src=3'b001, mask=0 -> irq_req=1, irq_id=0 after 4 edges;
//    ack -> pending=000, busy=1; eoi -> busy=0, state IDLE.
//  2 Priority: edges on src0 and src2 in the same cycle -> id=2 served first,
//    pending=001 after ack; after eoi, id=0 is requested 1 cycle later.
//  3 Mask: mask=3'b100, edge on src2 -> pending=100, irq_req stays 0; clear the
//    mask -> irq_req=1, id=2.
//  4 Set-vs-clear: new edge on src1 lands in the same cycle as its ack ->
//    pending[1] stays 1; after eoi it is requested again.
//  5 Level hold: src1 held high 20 cycles -> exactly one pending set and one service.
//  6 Async reset asserted in SERVICE mid-cycle -> all outputs 0 immediately;
//    eoi after release is ignored; state is IDLE.

Source files
------------

// File: rtl/irq_latch_arbiter_pkg.sv
// Shared types and default sizing for the interrupt latch/arbiter.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int unsigned N_SRC_DEF       = 3;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/irq_latch_arbiter_sync_edge_detect.sv
// One-bit synchroniser followed by a registered rising-edge pulse.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // The pulse is registered, adding one cycle after the last sync stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            o_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            o_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

endmodule

// File: rtl/irq_latch_arbiter.sv
// Latches interrupt edges as sticky pending bits, picks the highest unmasked
// index and runs a req/ack/eoi handshake with one interrupt in service.
module irq_latch_arbiter
    import irq_pkg::*;
#(
    parameter  int unsigned N_SRC       = N_SRC_DEF,
    parameter  int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int unsigned ID_W        = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_pending,
    output logic             irq_busy
);

    irq_state_t       r_state;
    logic             r_req;
    logic [ID_W-1:0]  r_id;
    logic             r_busy;
    logic [N_SRC-1:0] r_pending;

    irq_state_t       w_state_next;
    logic             w_req_next;
    logic [ID_W-1:0]  w_id_next;
    logic             w_busy_next;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_id_onehot;
    logic [ID_W-1:0]  w_win;
    logic             w_any;
    logic             w_cur_cand;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        sync_edge_detect #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .i_d    (irq_src[g]),
            .o_edge (w_edge[g])
        );
    end

    assign w_cand = r_pending & ~irq_mask;
    assign w_any  = |w_cand;

    // Ascending scan so the highest set index is the last to write.
    always_comb begin
        w_win = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_cand[i]) begin
                w_win = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_id_onehot = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            w_id_onehot[i] = (r_id == ID_W'(i));
        end
    end

    assign w_cur_cand = |(w_cand & w_id_onehot);

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_id_next    = r_id;
        w_busy_next  = r_busy;
        w_clr        = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_id_next    = w_win;
                    w_req_next   = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Ack wins over a same-cycle mask; no preemption while requesting.
                if (irq_ack) begin
                    w_clr        = w_id_onehot;
                    w_req_next   = 1'b0;
                    w_busy_next  = 1'b1;
                    w_state_next = SERVICE;
                end else if (!w_cur_cand) begin
                    w_req_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // A new edge on a bit being cleared keeps it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_id      <= '0;
            r_busy    <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_req     <= w_req_next;
            r_id      <= w_id_next;
            r_busy    <= w_busy_next;
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    assign irq_req     = r_req;
    assign irq_id      = r_id;
    assign irq_pending = r_pending;
    assign irq_busy    = r_busy;

endmodule

// File: tb/tb_irq_latch_arbiter.sv
// Directed scenarios plus randomized traffic checked against a cycle model.
module tb_irq_latch_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq_src;
    logic [N-1:0]  irq_mask;
    logic          irq_ack;
    logic          irq_eoi;
    logic          irq_req;
    logic [IW-1:0] irq_id;
    logic [N-1:0]  irq_pending;
    logic          irq_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sample history, pending set, handshake mode (0 idle, 1 req, 2 service).
    logic [N-1:0] m_h [5];
    logic [N-1:0] m_pend;
    int           m_mode;
    int           m_id;

    irq_latch_arbiter u_dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .irq_ack     (irq_ack),
        .irq_eoi     (irq_eoi),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_pending (irq_pending),
        .irq_busy    (irq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        logic [N-1:0] edges;
        logic [N-1:0] cand;
        logic [N-1:0] clr;
        if (rst) begin
            for (int j = 0; j < 5; j++) m_h[j] = '0;
            m_pend = '0;
            m_mode = 0;
            m_id   = 0;
        end else begin
            for (int j = 4; j > 0; j--) m_h[j] = m_h[j-1];
            m_h[0] = irq_src;
            // A rise sampled three edges ago becomes pending now.
            edges = m_h[3] & ~m_h[4];
            clr   = '0;
            cand  = m_pend & ~irq_mask;
            if (m_mode == 0) begin
                if (cand != 0) begin
                    for (int j = N - 1; j >= 0; j--) begin
                        if (cand[j]) begin
                            m_id = j;
                            break;
                        end
                    end
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (irq_ack) begin
                    clr[m_id] = 1'b1;
                    m_mode = 2;
                end else if (irq_mask[m_id]) begin
                    m_mode = 0;
                end
            end else begin
                if (irq_eoi) m_mode = 0;
            end
            m_pend = (m_pend & ~clr) | edges;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if (irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_req actual=%0b required=0", irq_req); end
        n_checks++;
        if (irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_id actual=%0d required=0", irq_id); end
        n_checks++;
        if (irq_pending !== 3'b000) begin n_fail++; $display("FAIL reset_pending actual=%b required=000", irq_pending); end
        n_checks++;
        if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%0b required=0", irq_busy); end
    endtask

    task automatic test_single_edge();
        irq_src = 3'b001;
        tick();
        irq_src = 3'b000;
        ticks(3);
        n_checks++;
        if (irq_req !== 1'b0 || irq_pending !== 3'b001) begin
            n_fail++; $display("FAIL single_early actual=req%0b/pend%b required=req0/pend001", irq_req, irq_pending);
        end
        tick();
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd0) begin
            n_fail++; $display("FAIL single_req actual=req%0b/id%0d required=req1/id0", irq_req, irq_id);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_checks++;
        if (irq_pending !== 3'b000 || irq_busy !== 1'b1 || irq_req !== 1'b0) begin
            n_fail++; $display("FAIL single_ack actual=pend%b/busy%0b/req%0b required=pend000/busy1/req0", irq_pending, irq_busy, irq_req);
        end
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick();
        n_checks++;
        if (irq_busy !== 1'b0 || irq_req !== 1'b0) begin
            n_fail++; $display("FAIL single_eoi actual=busy%0b/req%0b required=busy0/req0", irq_busy, irq_req);
        end
    endtask

    task automatic test_priority();
        irq_src = 3'b101;
        tick();
        irq_src = 3'b000;
        ticks(4);
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd2 || irq_pending !== 3'b101) begin
            n_fail++; $display("FAIL prio_first actual=req%0b/id%0d/pend%b required=req1/id2/pend101", irq_req, irq_id, irq_pending);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_checks++;
        if (irq_pending !== 3'b001 || irq_busy !== 1'b1) begin
            n_fail++; $display("FAIL prio_ack actual=pend%b/busy%0b required=pend001/busy1", irq_pending, irq_busy);
        end
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        n_checks++;
        if (irq_busy !== 1'b0 || irq_req !== 1'b0) begin
            n_fail++; $display("FAIL prio_eoi actual=busy%0b/req%0b required=busy0/req0", irq_busy, irq_req);
        end
        tick();
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd0) begin
            n_fail++; $display("FAIL prio_second actual=req%0b/id%0d required=req1/id0", irq_req, irq_id);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_mask();
        irq_mask = 3'b100;
        irq_src  = 3'b100;
        tick();
        irq_src = 3'b000;
        ticks(5);
        n_checks++;
        if (irq_pending !== 3'b100 || irq_req !== 1'b0) begin
            n_fail++; $display("FAIL mask_hold actual=pend%b/req%0b required=pend100/req0", irq_pending, irq_req);
        end
        irq_mask = 3'b000;
        tick();
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
            n_fail++; $display("FAIL mask_release actual=req%0b/id%0d required=req1/id2", irq_req, irq_id);
        end
        irq_mask = 3'b100;
        tick();
        n_checks++;
        if (irq_req !== 1'b0 || irq_pending !== 3'b100) begin
            n_fail++; $display("FAIL mask_in_req actual=req%0b/pend%b required=req0/pend100", irq_req, irq_pending);
        end
        irq_mask = 3'b000;
        tick();
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
            n_fail++; $display("FAIL mask_rereq actual=req%0b/id%0d required=req1/id2", irq_req, irq_id);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_set_vs_clear();
        irq_src = 3'b010;
        tick();
        irq_src = 3'b000;
        ticks(4);
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
            n_fail++; $display("FAIL svc_req actual=req%0b/id%0d required=req1/id1", irq_req, irq_id);
        end
        irq_src = 3'b010;
        tick();
        irq_src = 3'b000;
        ticks(2);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_checks++;
        if (irq_pending !== 3'b010 || irq_busy !== 1'b1) begin
            n_fail++; $display("FAIL svc_collide actual=pend%b/busy%0b required=pend010/busy1", irq_pending, irq_busy);
        end
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick();
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
            n_fail++; $display("FAIL svc_again actual=req%0b/id%0d required=req1/id1", irq_req, irq_id);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_checks++;
        if (irq_pending !== 3'b000) begin
            n_fail++; $display("FAIL svc_cleared actual=%b required=000", irq_pending);
        end
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_level_hold();
        int   services;
        logic prev_busy;
        services  = 0;
        prev_busy = irq_busy;
        irq_src = 3'b010;
        irq_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (irq_busy && !prev_busy) services++;
            prev_busy = irq_busy;
        end
        irq_ack = 1'b0;
        n_checks++;
        if (services !== 1 || irq_pending !== 3'b000 || irq_busy !== 1'b1) begin
            n_fail++; $display("FAIL level_hold actual=svc%0d/pend%b/busy%0b required=svc1/pend000/busy1", services, irq_pending, irq_busy);
        end
        irq_src = 3'b000;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        ticks(5);
        n_checks++;
        if (irq_req !== 1'b0 || irq_pending !== 3'b000 || irq_busy !== 1'b0) begin
            n_fail++; $display("FAIL level_after actual=req%0b/pend%b/busy%0b required=0/000/0", irq_req, irq_pending, irq_busy);
        end
    endtask

    task automatic test_reset_in_service();
        irq_src = 3'b001;
        tick();
        irq_src = 3'b000;
        ticks(4);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_src = 3'b100;
        tick();
        irq_src = 3'b000;
        ticks(3);
        n_checks++;
        if (irq_busy !== 1'b1 || irq_pending !== 3'b100) begin
            n_fail++; $display("FAIL rst_pre actual=busy%0b/pend%b required=busy1/pend100", irq_busy, irq_pending);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (irq_busy !== 1'b0 || irq_req !== 1'b0 || irq_pending !== 3'b000 || irq_id !== 2'd0) begin
            n_fail++; $display("FAIL rst_async actual=busy%0b/req%0b/pend%b/id%0d required=0/0/000/0", irq_busy, irq_req, irq_pending, irq_id);
        end
        tick();
        rst = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick();
        n_checks++;
        if (irq_busy !== 1'b0 || irq_req !== 1'b0 || irq_pending !== 3'b000) begin
            n_fail++; $display("FAIL rst_eoi actual=busy%0b/req%0b/pend%b required=0/0/000", irq_busy, irq_req, irq_pending);
        end
        irq_src = 3'b010;
        tick();
        irq_src = 3'b000;
        ticks(4);
        n_checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
            n_fail++; $display("FAIL rst_idle actual=req%0b/id%0d required=req1/id1", irq_req, irq_id);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) irq_src[b] = ~irq_src[b];
            end
            if ($urandom_range(15) == 0) irq_mask = 3'($urandom_range(7)) & 3'($urandom_range(7));
            irq_ack = ($urandom_range(2) == 0);
            irq_eoi = ($urandom_range(3) == 0);
            tick();
            n_checks++;
            if (irq_req !== (m_mode == 1)) begin
                n_fail++; $display("FAIL rand_req cyc=%0d actual=%0b required=%0b", k, irq_req, (m_mode == 1));
            end
            n_checks++;
            if (irq_busy !== (m_mode == 2)) begin
                n_fail++; $display("FAIL rand_busy cyc=%0d actual=%0b required=%0b", k, irq_busy, (m_mode == 2));
            end
            n_checks++;
            if (irq_id !== IW'(m_id)) begin
                n_fail++; $display("FAIL rand_id cyc=%0d actual=%0d required=%0d", k, irq_id, m_id);
            end
            n_checks++;
            if (irq_pending !== m_pend) begin
                n_fail++; $display("FAIL rand_pending cyc=%0d actual=%b required=%b", k, irq_pending, m_pend);
            end
        end
        irq_src  = '0;
        irq_mask = '0;
        irq_ack  = 1'b0;
        irq_eoi  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        irq_src  = '0;
        irq_mask = '0;
        irq_ack  = 1'b0;
        irq_eoi  = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();
        test_reset();
        test_single_edge();
        test_priority();
        test_mask();
        test_set_vs_clear();
        test_level_hold();
        test_reset_in_service();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
